sa_avalon_agent: RTL and testbench

SA_AVALON_AGENT -- requirements
Module: sa_avalon_agent

---
 rtl/sa_agent_pkg.sv | 33 +++
 rtl/sa_sync_fifo.sv | 54 +++++
 rtl/sa_avalon_agent.sv | 172 +++++++++++++++++
 tb/tb_sa_avalon_agent.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_agent_pkg.sv
// Shared register map, CTRL/STATUS bit positions and small helpers for the
// systolic-array Avalon agent.
package sa_agent_pkg;

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_STATUS   = 3'd1,
    REG_OP_FIFO  = 3'd2,
    REG_RES_FIFO = 3'd3,
    REG_DIM      = 3'd4,
    REG_SCRATCH  = 3'd5
  } sa_reg_e;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_FLUSH   = 2;

  localparam int STAT_BUSY        = 0;
  localparam int STAT_OP_FULL     = 1;
  localparam int STAT_RES_EMPTY   = 2;
  localparam int STAT_DONE        = 3;
  localparam int STAT_UNDERFLOW   = 4;
  localparam int STAT_OP_CNT_LSB  = 8;
  localparam int STAT_RES_CNT_LSB = 16;

  localparam logic [31:0] UNDERFLOW_RDATA = 32'h0000_0000;

  // A 256-deep FIFO can hold 256 entries; the 8-bit count field saturates.
  function automatic logic [7:0] cnt8(input logic [31:0] cnt);
    return (cnt > 32'd255) ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/sa_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear; the caller
// decides how clear interacts with push/pop.
module sa_sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign count = wptr - rptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr[AW-1:0]];

  // Push on full is fine when a pop frees the slot; pop on empty only with a
  // concurrent push, so the count stays put in both corner cases.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & (~empty | push);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sa_avalon_agent.sv
// Avalon-MM agent bridging a host to a systolic array: CTRL/STATUS registers,
// operand and result FIFOs. Define SA_AGENT_IRQ_EN to build the interrupt.
module sa_avalon_agent
  import sa_agent_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_readdatavalid,
  output logic                  avs_waitrequest,
  output logic [DATA_W-1:0]     op_data,
  output logic                  op_valid,
  input  logic                  op_ready,
  input  logic [DATA_W-1:0]     res_data,
  input  logic                  res_valid,
  output logic                  res_ready,
  output logic                  sa_start,
  input  logic                  sa_busy,
  output logic                  irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]     op_count;
  logic [CW-1:0]     res_count;
  logic              op_full;
  logic              op_empty;
  logic              res_full;
  logic              res_empty;
  logic [DATA_W-1:0] res_rdata;

  logic              op_xfer;
  logic              op_push;
  logic              op_pop;
  logic              res_push;
  logic              res_pop;
  logic              wr_acc;
  logic              ctrl_wr;
  logic              status_wr;
  logic              flush;
  logic              res_rd;
  logic              underflow_set;
  logic              done_set;
  logic [DATA_W-1:0] rd_mux;

  logic              busy_q;
  logic              done_q;
  logic              underflow_q;
  logic              ctrl_irq_en;
  logic [7:0]        dim_q;
  logic [DATA_W-1:0] scratch_q;

  assign op_valid  = ~op_empty;
  assign res_ready = ~res_full;

  // A stalled OP_FIFO write is released in the same cycle the array drains an
  // entry, so the push and pop land together.
  always_comb begin
    op_xfer         = op_valid & op_ready;
    avs_waitrequest = avs_write && (avs_address == REG_OP_FIFO) && op_full && !op_xfer;
    wr_acc          = avs_write & ~avs_waitrequest;
    ctrl_wr         = wr_acc && (avs_address == REG_CTRL) && avs_byteenable[0];
    status_wr       = wr_acc && (avs_address == REG_STATUS) && avs_byteenable[0];
    flush           = ctrl_wr & avs_writedata[CTRL_FLUSH];
    op_push         = wr_acc && (avs_address == REG_OP_FIFO) && !flush;
    op_pop          = op_xfer & ~flush;
    res_push        = res_valid & res_ready & ~flush;
    res_rd          = avs_read && (avs_address == REG_RES_FIFO);
    res_pop         = res_rd & ~res_empty & ~flush;
    underflow_set   = res_rd & res_empty;
    done_set        = busy_q & ~sa_busy;
  end

  sa_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_op_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .push  (op_push),
    .pop   (op_pop),
    .wdata (avs_writedata),
    .rdata (op_data),
    .count (op_count),
    .full  (op_full),
    .empty (op_empty)
  );

  sa_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .push  (res_push),
    .pop   (res_pop),
    .wdata (res_data),
    .rdata (res_rdata),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      REG_CTRL:     rd_mux[CTRL_IRQ_EN] = ctrl_irq_en;
      REG_STATUS: begin
        rd_mux[STAT_BUSY]                  = sa_busy;
        rd_mux[STAT_OP_FULL]               = op_full;
        rd_mux[STAT_RES_EMPTY]             = res_empty;
        rd_mux[STAT_DONE]                  = done_q;
        rd_mux[STAT_UNDERFLOW]             = underflow_q;
        rd_mux[STAT_OP_CNT_LSB +: 8]       = cnt8(32'(op_count));
        rd_mux[STAT_RES_CNT_LSB +: 8]      = cnt8(32'(res_count));
      end
      REG_RES_FIFO: rd_mux = res_empty ? DATA_W'(UNDERFLOW_RDATA) : res_rdata;
      REG_DIM:      rd_mux[7:0] = dim_q;
      REG_SCRATCH:  rd_mux = scratch_q;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= '0;
      sa_start          <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      underflow_q       <= 1'b0;
      dim_q             <= '0;
      scratch_q         <= '0;
    end else begin
      avs_readdatavalid <= avs_read;
      avs_readdata      <= avs_read ? rd_mux : '0;
      sa_start          <= ctrl_wr & avs_writedata[CTRL_START];
      busy_q            <= sa_busy;
      // Set beats a coincident write-one-to-clear.
      done_q            <= done_set | (done_q & ~(status_wr & avs_writedata[STAT_DONE]));
      underflow_q       <= underflow_set |
                           (underflow_q & ~(status_wr & avs_writedata[STAT_UNDERFLOW]));
      if (wr_acc && (avs_address == REG_DIM) && avs_byteenable[0])
        dim_q <= avs_writedata[7:0];
      if (wr_acc && (avs_address == REG_SCRATCH)) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (avs_byteenable[b]) scratch_q[b*8 +: 8] <= avs_writedata[b*8 +: 8];
        end
      end
    end
  end

`ifdef SA_AGENT_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_irq_en <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_irq_en <= avs_writedata[CTRL_IRQ_EN];
      irq <= ctrl_irq_en & done_q;
    end
  end
`else
  assign ctrl_irq_en = 1'b0;
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_sa_avalon_agent.sv
// Directed self-checking bench for sa_avalon_agent (DATA_W=32, FIFO_DEPTH=16).
module tb_sa_avalon_agent;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_OP      = 3'd2;
  localparam logic [2:0] A_RES     = 3'd3;
  localparam logic [2:0] A_DIM     = 3'd4;
  localparam logic [2:0] A_SCRATCH = 3'd5;

`ifdef SA_AGENT_IRQ_EN
  localparam logic IRQ_BUILT = 1'b1;
`else
  localparam logic IRQ_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic [31:0] op_data;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic [31:0] res_data = '0;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic        sa_start;
  logic        sa_busy = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  sa_avalon_agent #(.DATA_W(32), .FIFO_DEPTH(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .op_data           (op_data),
    .op_valid          (op_valid),
    .op_ready          (op_ready),
    .res_data          (res_data),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .sa_start          (sa_start),
    .sa_busy           (sa_busy),
    .irq               (irq)
  );

  always #5 clk = ~clk;

  task automatic av_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    #1;
    while (avs_waitrequest && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (avs_waitrequest) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%0d waitrequest still %b, required 0", a, avs_waitrequest);
    end
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic av_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
    v = avs_readdatavalid;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({avs_readdatavalid, sa_start, op_valid, irq, res_ready, avs_waitrequest} !== 6'b000010 ||
        avs_readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs rdv/start/opv/irq/rready/wait=%b%b%b%b%b%b rdata=%h, required 000010 rdata=0",
               avs_readdatavalid, sa_start, op_valid, irq, res_ready, avs_waitrequest, avs_readdata);
    end
    @(negedge clk); reset = 1'b0;
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'h4 || v !== 1'b1) begin errors++; $display("FAIL reset_status got %h v=%b, required 00000004 v=1", d, v); end
    av_read(A_CTRL, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h, required 0", d); end
    av_read(A_SCRATCH, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_scratch got %h, required 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d; logic v;
    av_write(A_SCRATCH, 32'h1234_5678, 4'b0011);
    av_read(A_SCRATCH, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0000_5678) begin errors++; $display("FAIL scratch_be got %h v=%b, required 00005678 v=1", d, v); end
    @(posedge clk); #1;
    checks++; if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin errors++; $display("FAIL rdv_one_cycle got v=%b d=%h, required v=0 d=0", avs_readdatavalid, avs_readdata); end
    av_write(A_DIM, 32'hABCD, 4'b1111);
    av_write(A_DIM, 32'hFF, 4'b1110);
    av_read(A_DIM, d, v);
    checks++; if (d !== 32'hCD) begin errors++; $display("FAIL dim_be got %h, required 000000cd", d); end
    av_write(3'd6, 32'hFFFF_FFFF, 4'b1111);
    av_read(3'd6, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL addr6 got %h v=%b, required 0 v=1", d, v); end
  endtask

  task automatic test_underflow();
    logic [31:0] d; logic v;
    av_read(A_RES, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL underflow_read got %h v=%b, required 0 v=1", d, v); end
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'h14) begin errors++; $display("FAIL underflow_flag got %h, required 00000014", d); end
    av_write(A_STATUS, 32'h10, 4'b1111);
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL underflow_w1c got %h, required 00000004", d); end
  endtask

  task automatic test_res_fifo();
    logic [31:0] d; logic v;
    @(negedge clk); res_valid = 1'b1; res_data = 32'hCAFE_0001;
    @(negedge clk); res_data = 32'hCAFE_0002;
    @(negedge clk); res_valid = 1'b0;
    av_read(A_RES, d, v);
    checks++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL res_first got %h, required cafe0001", d); end
    av_read(A_RES, d, v);
    checks++; if (d !== 32'hCAFE_0002) begin errors++; $display("FAIL res_second got %h, required cafe0002", d); end
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL res_drained got %h, required 00000004", d); end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk); res_valid = 1'b1; res_data = 32'(i);
    end
    @(negedge clk); res_valid = 1'b0; #1;
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL res_full_ready got %b, required 0", res_ready); end
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'h0010_0000) begin errors++; $display("FAIL res_full_count got %h, required 00100000", d); end
    av_write(A_CTRL, 32'h4, 4'b1111);
  endtask

  task automatic test_op_fifo();
    logic [31:0] d; logic v;
    op_ready = 1'b0;
    for (int i = 1; i <= 16; i++) av_write(A_OP, 32'(i), 4'b1111);
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'h1006) begin errors++; $display("FAIL op_full_status got %h, required 00001006", d); end
    fork
      av_write(A_OP, 32'd17, 4'b1111);
      begin
        repeat (2) @(negedge clk);
        #2;
        checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL op_stall got waitrequest=%b, required 1", avs_waitrequest); end
        @(negedge clk);
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
      end
    join
    av_read(A_STATUS, d, v);
    checks++; if (d[15:8] !== 8'd16 || d !== 32'h1006) begin errors++; $display("FAIL op_after_drain got %h, required 00001006", d); end
    @(negedge clk); op_ready = 1'b1;
    for (int i = 2; i <= 17; i++) begin
      #1;
      checks++;
      if (op_valid !== 1'b1 || op_data !== 32'(i)) begin
        errors++; $display("FAIL op_order got valid=%b data=%h, required valid=1 data=%h", op_valid, op_data, 32'(i));
      end
      @(negedge clk);
    end
    op_ready = 1'b0; #1;
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL op_empty got op_valid=%b, required 0", op_valid); end
  endtask

  task automatic test_done_irq();
    logic [31:0] d; logic v;
    av_write(A_CTRL, 32'h3, 4'b1111);
    checks++; if (sa_start !== 1'b1) begin errors++; $display("FAIL start_pulse got %b, required 1", sa_start); end
    @(posedge clk); #1;
    checks++; if (sa_start !== 1'b0) begin errors++; $display("FAIL start_width got %b, required 0", sa_start); end
    @(negedge clk); sa_busy = 1'b1;
    repeat (2) @(negedge clk);
    sa_busy = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (irq !== IRQ_BUILT) begin errors++; $display("FAIL irq_set got %b, required %b", irq, IRQ_BUILT); end
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'hC) begin errors++; $display("FAIL done_set got %h, required 0000000c", d); end
    av_read(A_CTRL, d, v);
    checks++; if (d !== {30'd0, IRQ_BUILT, 1'b0}) begin errors++; $display("FAIL ctrl_irq_en got %h, required %h", d, {30'd0, IRQ_BUILT, 1'b0}); end
    av_write(A_STATUS, 32'h8, 4'b1111);
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b, required 0", irq); end
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL done_w1c got %h, required 00000004", d); end
    // busy fall coincident with W1C of DONE
    @(negedge clk); sa_busy = 1'b1;
    @(negedge clk);
    avs_address = A_STATUS; avs_writedata = 32'h8; avs_byteenable = 4'hF; avs_write = 1'b1;
    sa_busy = 1'b0;
    @(posedge clk); #1; avs_write = 1'b0;
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'hC) begin errors++; $display("FAIL done_set_wins got %h, required 0000000c", d); end
    av_write(A_STATUS, 32'h8, 4'b1111);
    av_write(A_CTRL, 32'h0, 4'b1111);
  endtask

  task automatic test_flush();
    logic [31:0] d; logic v;
    av_write(A_OP, 32'h11, 4'b1111);
    av_write(A_OP, 32'h22, 4'b1111);
    @(negedge clk); #1;
    checks++; if (op_valid !== 1'b1 || op_data !== 32'h11) begin errors++; $display("FAIL op_head got v=%b d=%h, required v=1 d=11", op_valid, op_data); end
    @(negedge clk); res_valid = 1'b1; res_data = 32'hA0;
    @(negedge clk); res_data = 32'hA1;
    @(negedge clk); res_data = 32'hA2;
    @(negedge clk); res_valid = 1'b0;
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'h0003_0200) begin errors++; $display("FAIL pre_flush got %h, required 00030200", d); end
    @(negedge clk);
    res_valid = 1'b1; res_data = 32'hA3;
    avs_address = A_CTRL; avs_writedata = 32'h4; avs_byteenable = 4'hF; avs_write = 1'b1;
    @(posedge clk); #1;
    avs_write = 1'b0; res_valid = 1'b0;
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL flush_status got %h, required 00000004", d); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL flush_op got op_valid=%b, required 0", op_valid); end
  endtask

  task automatic test_reset_stall();
    logic [31:0] d; logic v;
    op_ready = 1'b0;
    av_write(A_DIM, 32'h5A, 4'b1111);
    for (int i = 0; i < 16; i++) av_write(A_OP, 32'(i), 4'b1111);
    @(negedge clk);
    avs_address = A_OP; avs_writedata = 32'h99; avs_byteenable = 4'hF; avs_write = 1'b1;
    #1;
    checks++; if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL stall_before_reset got %b, required 1", avs_waitrequest); end
    @(negedge clk); reset = 1'b1; #1;
    checks++;
    if ({avs_waitrequest, op_valid, res_ready, avs_readdatavalid, sa_start, irq} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_stall wait/opv/rready/rdv/start/irq=%b%b%b%b%b%b, required 001000",
               avs_waitrequest, op_valid, res_ready, avs_readdatavalid, sa_start, irq);
    end
    avs_write = 1'b0;
    @(negedge clk); reset = 1'b0;
    av_read(A_STATUS, d, v);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL reset_fifos got %h, required 00000004", d); end
    av_read(A_DIM, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_dim got %h, required 0", d); end
    av_write(A_SCRATCH, 32'hDEAD_BEEF, 4'b1111);
    av_read(A_SCRATCH, d, v);
    reset = 1'b1; #1;
    checks++; if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_pending_read got v=%b d=%h, required v=0 d=0", avs_readdatavalid, avs_readdata); end
    @(negedge clk); reset = 1'b0;
    av_read(A_SCRATCH, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_scratch2 got %h, required 0", d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_underflow();
    test_res_fifo();
    test_op_fifo();
    test_done_irq();
    test_flush();
    test_reset_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation time exceeded, required completion");
    $fatal(1);
  end

endmodule
